// File: rtl/input_debounce_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : input_debounce_conditioner
// Brief    : Per-bit synchroniser and debouncer with change strobe/mask and a
//            saturating accepted-change counter.
// Revision : 1.0
// ============================================================================
module input_debounce_conditioner #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             cnt_clear,
    output logic [WIDTH-1:0] stable_out,
    output logic             change_pulse,
    output logic [WIDTH-1:0] change_mask,
    output logic [7:0]       change_count
);

    localparam logic [7:0] c_cnt_max   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_count_sat = 8'hFF;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_flag;
    logic [7:0]       r_cnt [WIDTH];
    logic [7:0]       r_count;

    // Plain flop chain: nothing may sit between stages.
    for (genvar j = 0; j < SYNC_STAGES; j++) begin : g_sync
        if (j == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync[j] <= RESET_VALUE;
                else       r_sync[j] <= din;
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync[j] <= RESET_VALUE;
                else       r_sync[j] <= r_sync[j-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_flag = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_flag[i] = en && (w_s[i] != r_stable[i]) && (r_cnt[i] == c_cnt_max);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= RESET_VALUE;
            r_mask   <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 8'd0;
        end else begin
            r_mask <= w_flag;
            for (int i = 0; i < WIDTH; i++) begin
                if (!en || (w_s[i] == r_stable[i])) begin
                    r_cnt[i] <= 8'd0;
                end else if (w_flag[i]) begin
                    r_stable[i] <= w_s[i];
                    r_cnt[i]    <= 8'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Counter steps on the same edge that registers the mask; clear wins but
    // still counts a coincident change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (cnt_clear) begin
            r_count <= (|w_flag) ? 8'd1 : 8'd0;
        end else if ((|w_flag) && (r_count != c_count_sat)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign stable_out   = r_stable;
    assign change_mask  = r_mask;
    assign change_pulse = |r_mask;
    assign change_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_input_debounce_conditioner
// Brief    : Directed self-checking bench; D=16 and D=1 instances.
// Revision : 1.0
// ============================================================================
module tb_input_debounce_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [7:0] din_a, din_b;
    logic       clr_a, clr_b;
    logic [7:0] stable_a, stable_b;
    logic       pulse_a, pulse_b;
    logic [7:0] mask_a, mask_b;
    logic [7:0] count_a, count_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse_a = 0;
    int p0;

    always #5 clk = ~clk;

    input_debounce_conditioner #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_VALUE(8'h00)
    ) u_dut_a (
        .clk(clk), .reset(reset), .en(en_a), .din(din_a), .cnt_clear(clr_a),
        .stable_out(stable_a), .change_pulse(pulse_a), .change_mask(mask_a),
        .change_count(count_a)
    );

    input_debounce_conditioner #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(8'h00)
    ) u_dut_b (
        .clk(clk), .reset(reset), .en(en_b), .din(din_b), .cnt_clear(clr_b),
        .stable_out(stable_b), .change_pulse(pulse_b), .change_mask(mask_b),
        .change_count(count_b)
    );

    always @(negedge clk) if (pulse_a) n_pulse_a++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en_a = 1'b1; en_b = 1'b1;
        din_a = 8'h00; din_b = 8'h00;
        clr_a = 1'b0; clr_b = 1'b0;
        step(2);
        chk("rst_stable", stable_a, 8'h00);
        chk("rst_pulse", pulse_a, 1'b0);
        chk("rst_mask", mask_a, 8'h00);
        chk("rst_count", count_a, 8'h00);
        reset = 1'b0;

        // Single bit rise: accepted exactly 17 edges after first sample.
        din_a = 8'h01;
        p0 = n_pulse_a;
        step(17);
        chk("lat_before", stable_a, 8'h00);
        step(1);
        chk("lat_stable", stable_a, 8'h01);
        chk("lat_pulse", pulse_a, 1'b1);
        chk("lat_mask", mask_a, 8'h01);
        chk("lat_count", count_a, 8'h01);
        step(1);
        chk("lat_pulse_off", pulse_a, 1'b0);
        chk("lat_mask_off", mask_a, 8'h00);
        chk("lat_npulse", n_pulse_a - p0, 1);

        // Bit 3 bounce, 15-cycle highs: never accepted.
        p0 = n_pulse_a;
        for (int r = 0; r < 5; r++) begin
            din_a = 8'h09;
            step(15);
            din_a = 8'h01;
            step(15);
        end
        step(20);
        chk("glitch_stable", stable_a, 8'h01);
        chk("glitch_npulse", n_pulse_a - p0, 0);
        chk("glitch_count", count_a, 8'h01);

        // Multi-bit change on one edge: one pulse, one count.
        do_reset();
        chk("rst2_count", count_a, 8'h00);
        din_a = 8'hA5;
        p0 = n_pulse_a;
        step(17);
        chk("multi_before", stable_a, 8'h00);
        step(1);
        chk("multi_stable", stable_a, 8'hA5);
        chk("multi_mask", mask_a, 8'hA5);
        chk("multi_count", count_a, 8'h01);
        step(5);
        chk("multi_npulse", n_pulse_a - p0, 1);
        chk("multi_count2", count_a, 8'h01);

        // Enable low: sync settles, nothing accepted; full window after enable.
        do_reset();
        en_a = 1'b0;
        din_a = 8'hFF;
        p0 = n_pulse_a;
        step(30);
        chk("en0_stable", stable_a, 8'h00);
        chk("en0_npulse", n_pulse_a - p0, 0);
        en_a = 1'b1;
        step(15);
        chk("en1_before", stable_a, 8'h00);
        step(1);
        chk("en1_stable", stable_a, 8'hFF);
        chk("en1_mask", mask_a, 8'hFF);
        chk("en1_count", count_a, 8'h01);

        // Asynchronous reset with a pending change at count 10.
        din_a = 8'h0F;
        step(12);
        chk("mid_before", stable_a, 8'hFF);
        #2;
        reset = 1'b1;
        #1;
        chk("async_stable", stable_a, 8'h00);
        chk("async_count", count_a, 8'h00);
        reset = 1'b0;
        step(17);
        chk("relat_before", stable_a, 8'h00);
        step(1);
        chk("relat_stable", stable_a, 8'h0F);
        chk("relat_mask", mask_a, 8'h0F);

        // D=1 instance: two-edge latency, saturation, clear with a change.
        do_reset();
        din_b = 8'h01;
        step(2);
        chk("d1_before", stable_b, 8'h00);
        step(1);
        chk("d1_stable", stable_b, 8'h01);
        chk("d1_pulse", pulse_b, 1'b1);
        chk("d1_count", count_b, 8'h01);
        for (int i = 0; i < 265; i++) begin
            din_b = din_b ^ 8'h01;
            step(1);
        end
        chk("sat_count", count_b, 8'hFF);
        din_b = din_b ^ 8'h01;
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        chk("clr_pulse", pulse_b, 1'b1);
        chk("clr_count", count_b, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
